// File: rtl/enc_pkg.sv
// Shared types and helpers for the encoder8to3_queue request encoder.
package enc_pkg;

    localparam int INPUTS_DEFAULT = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } enc_state_t;

    // Clearing the lowest set bit leaves a nonzero value only if two or more bits were set.
    function automatic logic more_than_one(input logic [15:0] vec);
        return ((vec & (vec - 16'd1)) != 16'd0);
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational request picker: fixed highest-index priority, or a round-robin
// search upward from a start pointer with wrap-around.
module prio_pick #(
    parameter int   INPUTS      = 8,
    parameter int   IDX_W       = $clog2(INPUTS),
    parameter logic ROUND_ROBIN = 1'b0
) (
    input  logic [INPUTS-1:0] vec_i,
    input  logic [IDX_W-1:0]  start_i,
    output logic [IDX_W-1:0]  idx_o,
    output logic              found_o
);

    logic [IDX_W-1:0] pick_s;
    logic [IDX_W-1:0] pos_s;

    assign found_o = |vec_i;
    assign idx_o   = pick_s;

    generate
        if (ROUND_ROBIN) begin : g_rr
            // Scan from farthest to nearest so the first set bit at or above start_i wins.
            always_comb begin
                pick_s = {IDX_W{1'b0}};
                pos_s  = {IDX_W{1'b0}};
                for (int k = INPUTS - 1; k >= 0; k--) begin
                    pos_s  = start_i + IDX_W'(k);
                    pick_s = vec_i[pos_s] ? pos_s : pick_s;
                end
            end
        end else begin : g_fixed
            // Ascending scan: the highest set index is the last one to be taken.
            always_comb begin
                pick_s = {IDX_W{1'b0}};
                pos_s  = start_i;
                for (int i = 0; i < INPUTS; i++) begin
                    pick_s = vec_i[i] ? IDX_W'(i) : pick_s;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/encoder8to3_queue.sv
// Registered priority encoder with sticky request capture and a valid/ready output.
// Define ENC_ROUND_ROBIN_EN for a round-robin pick; otherwise highest index wins.
module encoder8to3_queue
    import enc_pkg::*;
#(
    parameter int INPUTS = INPUTS_DEFAULT,
    parameter int IDX_W  = $clog2(INPUTS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INPUTS-1:0] req,
    output logic [IDX_W-1:0]  idx,
    output logic              valid,
    input  logic              ready,
    output logic              multi,
    output logic [INPUTS-1:0] pending
);

    enc_state_t        state_q, state_d;
    logic [INPUTS-1:0] pending_q, pending_d;
    logic [INPUTS-1:0] clr_s;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              valid_q, valid_d;
    logic              multi_q, multi_d;
    logic [IDX_W-1:0]  pick_idx_s;
    logic              pick_found_s;
    logic [IDX_W-1:0]  start_s;
    logic              load_s;
    logic              handshake_s;
    logic [15:0]       pend_ext_s;

`ifdef ENC_ROUND_ROBIN_EN
    localparam logic RR_SEL = 1'b1;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    assign start_s = ptr_q;
`else
    localparam logic RR_SEL = 1'b0;
    assign start_s = {IDX_W{1'b0}};
`endif

    prio_pick #(
        .INPUTS      (INPUTS),
        .IDX_W       (IDX_W),
        .ROUND_ROBIN (RR_SEL)
    ) u_pick (
        .vec_i   (pending_q),
        .start_i (start_s),
        .idx_o   (pick_idx_s),
        .found_o (pick_found_s)
    );

    // Next-state, load decision and pending-bit bookkeeping.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        multi_d     = multi_q;
        load_s      = 1'b0;
        handshake_s = valid_q & ready;
        pend_ext_s  = 16'd0;
        pend_ext_s[INPUTS-1:0] = pending_q;

        case (state_q)
            IDLE: begin
                if (pick_found_s) begin
                    load_s  = 1'b1;
                    state_d = HOLD;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (handshake_s) begin
                    if (pick_found_s) begin
                        load_s  = 1'b1;
                        state_d = HOLD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load_s) begin
            idx_d   = pick_idx_s;
            multi_d = more_than_one(pend_ext_s);
            clr_s   = {{(INPUTS-1){1'b0}}, 1'b1} << pick_idx_s;
        end else begin
            clr_s   = {INPUTS{1'b0}};
        end

        // A request arriving on its own clear edge re-sets the bit.
        pending_d = (pending_q & ~clr_s) | req;
        valid_d   = (state_d == HOLD);
    end

`ifdef ENC_ROUND_ROBIN_EN
    // Pointer sits one past the most recently loaded index.
    always_comb begin
        if (load_s) begin
            ptr_d = pick_idx_s + {{(IDX_W-1){1'b0}}, 1'b1};
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= {IDX_W{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Output and request-capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= {INPUTS{1'b0}};
            idx_q     <= {IDX_W{1'b0}};
            valid_q   <= 1'b0;
            multi_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            multi_q   <= multi_d;
        end
    end

    assign idx     = idx_q;
    assign valid   = valid_q;
    assign multi   = multi_q;
    assign pending = pending_q;

endmodule
